// File: rtl/cache_arbiter_if.sv
// Bundle of cache request/response and RAM port signals seen by cache_arbiter.
// slave = arbiter view; master = caches plus RAM model view.
interface cache_arbiter_if #(
   parameter int CPUS = 2
);
   logic [CPUS-1:0]       iREN;
   logic [CPUS-1:0][31:0] iaddr;
   logic [CPUS-1:0]       dREN;
   logic [CPUS-1:0]       dWEN;
   logic [CPUS-1:0][31:0] daddr;
   logic [CPUS-1:0][31:0] dstore;
   logic [CPUS-1:0]       iwait;
   logic [CPUS-1:0]       dwait;
   logic [CPUS-1:0][31:0] iload;
   logic [CPUS-1:0][31:0] dload;
   logic                  ramREN;
   logic                  ramWEN;
   logic [31:0]           ramaddr;
   logic [31:0]           ramstore;
   logic [31:0]           ramload;
   logic [1:0]            ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one RAM port between all icache/dcache ports; data beats instruction.
// Optional CACHE_ARB_AGE_EN promotes icache requests that lost AGE_LIMIT arbitrations in a row.
module cache_arbiter #(
   parameter int CPUS      = 2,
   parameter int AGE_LIMIT = 8
) (
   input  logic            CLK,
   input  logic            nRST,
   cache_arbiter_if.slave  bus
);

   localparam int         CW         = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {IDLE, BUSY} state_t;

   if (CPUS < 1 || AGE_LIMIT < 1) begin : g_param_check
      $error("cache_arbiter: CPUS and AGE_LIMIT must be at least 1");
   end

   state_t          state_q, state_d;
   logic [CW-1:0]   gnt_cpu_q, gnt_cpu_d;
   logic            gnt_data_q, gnt_data_d;
   logic [CW-1:0]   ptr_q, ptr_d;

   logic [CPUS-1:0] d_req;
   logic [CW:0]     d_pick, i_pick;
   logic            win_found, win_data;
   logic [CW-1:0]   win_cpu;
   logic            req_live;

   assign d_req     = bus.dREN | bus.dWEN;
   assign bus.iload = {CPUS{bus.ramload}};
   assign bus.dload = {CPUS{bus.ramload}};

   // Returns {found, index} of the first set request at or after ptr, wrapping modulo CPUS.
   function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req, input logic [CW-1:0] ptr);
      logic [CW:0] res;
      int          idx;
      res = '0;
      for (int k = CPUS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= CPUS) idx = idx - CPUS;
         if (req[CW'(idx)]) res = {1'b1, CW'(idx)};
      end
      return res;
   endfunction

`ifdef CACHE_ARB_AGE_EN
   localparam int AW = $clog2(AGE_LIMIT + 1);

   logic [AW-1:0]   age_q [CPUS];
   logic [AW-1:0]   age_d [CPUS];
   logic [CPUS-1:0] promoted;
   logic [CW:0]     p_pick;

   always_comb begin
      for (int i = 0; i < CPUS; i++) begin
         promoted[i] = bus.iREN[i] && (age_q[i] == AW'(AGE_LIMIT));
      end
   end
`endif

   always_comb begin
      d_pick    = rr_pick(d_req, ptr_q);
      i_pick    = rr_pick(bus.iREN, ptr_q);
      win_found = d_pick[CW] | i_pick[CW];
      win_data  = d_pick[CW];
      win_cpu   = d_pick[CW] ? d_pick[CW-1:0] : i_pick[CW-1:0];
`ifdef CACHE_ARB_AGE_EN
      p_pick = rr_pick(promoted, ptr_q);
      if (p_pick[CW]) begin
         win_data = 1'b0;
         win_cpu  = p_pick[CW-1:0];
      end
`endif
   end

`ifdef CACHE_ARB_AGE_EN
   // Counters saturate at AGE_LIMIT so a promoted request stays promoted until granted.
   always_comb begin
      for (int i = 0; i < CPUS; i++) begin
         age_d[i] = age_q[i];
         if (!bus.iREN[i]) begin
            age_d[i] = '0;
         end else if (state_q == IDLE && win_found) begin
            if (!win_data && win_cpu == CW'(i)) age_d[i] = '0;
            else if (age_q[i] != AW'(AGE_LIMIT)) age_d[i] = age_q[i] + 1'b1;
         end
      end
   end

   // NOTE: the age counters are a small register array, reset like any other state so
   // aging always restarts from zero after nRST.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < CPUS; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < CPUS; i++) age_q[i] <= age_d[i];
      end
   end
`endif

   // NOTE: every signal written here gets a default first so no path leaves it unassigned
   // (which would infer a latch).
   always_comb begin
      state_d      = state_q;
      gnt_cpu_d    = gnt_cpu_q;
      gnt_data_d   = gnt_data_q;
      ptr_d        = ptr_q;
      req_live     = 1'b0;
      bus.iwait    = '1;
      bus.dwait    = '1;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = BUSY;
               gnt_cpu_d  = win_cpu;
               gnt_data_d = win_data;
            end
         end
         BUSY: begin
            if (gnt_data_q) begin
               bus.ramREN   = bus.dREN[gnt_cpu_q];
               bus.ramWEN   = bus.dWEN[gnt_cpu_q];
               bus.ramaddr  = bus.daddr[gnt_cpu_q];
               bus.ramstore = bus.dstore[gnt_cpu_q];
               req_live     = d_req[gnt_cpu_q];
            end else begin
               bus.ramREN   = bus.iREN[gnt_cpu_q];
               bus.ramaddr  = bus.iaddr[gnt_cpu_q];
               req_live     = bus.iREN[gnt_cpu_q];
            end

            if (bus.ramstate == RAM_ACCESS) begin
               if (gnt_data_q) bus.dwait[gnt_cpu_q] = 1'b0;
               else            bus.iwait[gnt_cpu_q] = 1'b0;
               ptr_d   = (gnt_cpu_q == CW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;
               state_d = IDLE;
            end else if (!req_live) begin
               // Abandoned before completion: pointer untouched, no wait bit released.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         gnt_cpu_q  <= '0;
         gnt_data_q <= 1'b0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_cpu_q  <= gnt_cpu_d;
         gnt_data_q <= gnt_data_d;
         ptr_q      <= ptr_d;
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter (CPUS=2): directed vector table, hand sequences,
// and randomized traffic against a transaction-level reference model.
module tb_cache_arbiter;

   localparam int         N         = 2;
   localparam int         AGE_LIM   = 8;
   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   cache_arbiter_if #(.CPUS(N)) bus ();

   cache_arbiter #(.CPUS(N), .AGE_LIMIT(AGE_LIM)) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  iren;
      logic [1:0]  dren;
      logic [1:0]  dwen;
      logic [1:0]  rs;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [1:0]  iwait;
      logic [1:0]  dwait;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   bit m_busy;
   int m_cpu;
   bit m_data;
   int m_ptr;
   int m_age[N];

   logic        e_ren, e_wen;
   logic [31:0] e_addr, e_store;
   logic [1:0]  e_iwait, e_dwait;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] outs(input logic ren, input logic wen, input logic [31:0] a,
                                          input logic [31:0] s, input logic [1:0] iw, input logic [1:0] dw);
      return {58'd0, ren, wen, a, s, iw, dw};
   endfunction

   function automatic logic [127:0] dut_outs();
      return outs(bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait);
   endfunction

   function automatic vec_t mk(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                               input logic [1:0] rs, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] store,
                               input logic [1:0] iwait, input logic [1:0] dwait);
      vec_t v;
      v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
      v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
      v.iwait = iwait; v.dwait = dwait;
      return v;
   endfunction

   task automatic clear_inputs();
      bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
      bus.ramload = '0; bus.ramstate = RS_FREE;
   endtask

   task automatic fixed_addrs();
      bus.iaddr[0]  = 32'h40;   bus.iaddr[1]  = 32'h140;
      bus.daddr[0]  = 32'h200;  bus.daddr[1]  = 32'h80;
      bus.dstore[0] = 32'h5555; bus.dstore[1] = 32'h1234;
      bus.ramload   = 32'hDEADBEEF;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 0; m_cpu = 0; m_data = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
   endtask

   // Expected outputs for this cycle from the model's grant and the live inputs.
   task automatic model_outputs();
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iwait = '1; e_dwait = '1;
      if (m_busy) begin
         if (m_data) begin
            e_ren = bus.dREN[m_cpu]; e_wen = bus.dWEN[m_cpu];
            e_addr = bus.daddr[m_cpu]; e_store = bus.dstore[m_cpu];
         end else begin
            e_ren = bus.iREN[m_cpu]; e_addr = bus.iaddr[m_cpu];
         end
         if (bus.ramstate == RS_ACCESS) begin
            if (m_data) e_dwait[m_cpu] = 1'b0;
            else        e_iwait[m_cpu] = 1'b0;
         end
      end
   endtask

   // Advance the model by one clock using the inputs held during this cycle.
   task automatic model_step();
      int  order[$];
      int  chosen;
      bit  chosen_data;
      bit  has_req;
      if (m_busy) begin
         has_req = m_data ? (bus.dREN[m_cpu] | bus.dWEN[m_cpu]) : bus.iREN[m_cpu];
         if (bus.ramstate == RS_ACCESS) begin
            m_busy = 0;
            m_ptr  = (m_cpu + 1) % N;
         end else if (!has_req) begin
            m_busy = 0;
         end
         for (int c = 0; c < N; c++) if (!bus.iREN[c]) m_age[c] = 0;
      end else begin
         for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
         chosen = -1;
         chosen_data = 0;
`ifdef CACHE_ARB_AGE_EN
         foreach (order[j]) if (chosen < 0 && bus.iREN[order[j]] && m_age[order[j]] >= AGE_LIM) chosen = order[j];
`endif
         if (chosen < 0) foreach (order[j]) if (chosen < 0 && (bus.dREN[order[j]] || bus.dWEN[order[j]])) begin
            chosen = order[j];
            chosen_data = 1;
         end
         if (chosen < 0) foreach (order[j]) if (chosen < 0 && bus.iREN[order[j]]) chosen = order[j];
         for (int c = 0; c < N; c++) begin
            if (!bus.iREN[c]) m_age[c] = 0;
            else if (!chosen_data && chosen == c) m_age[c] = 0;
            else if (m_age[c] < AGE_LIM) m_age[c] = m_age[c] + 1;
         end
         if (chosen >= 0) begin
            m_busy = 1; m_cpu = chosen; m_data = chosen_data;
         end
      end
   endtask

   initial begin
      int          alt_order[$];
      int          low_cnt[N];
      int          i_low_cnt, first_i_low, d0_low_cnt;
      logic [1:0]  dsel;

      rst_n = 1'b0;
      clear_inputs();
      #1;
      check("reset_outputs", dut_outs(), outs(0, 0, 0, 0, 2'b11, 2'b11));
      @(negedge clk);
      bus.dREN = 2'b11; bus.iREN = 2'b11; bus.ramstate = RS_ACCESS;
      @(negedge clk);
      #1;
      check("reset_held_outputs", dut_outs(), outs(0, 0, 0, 0, 2'b11, 2'b11));
      do_reset();
      fixed_addrs();

      // ---------------- directed vector table ----------------
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_BUSY,   1, 0, 32'h40,  32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_BUSY,   1, 0, 32'h40,  32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_BUSY,   1, 0, 32'h40,  32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_ACCESS, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b10, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b10, RS_ACCESS, 0, 1, 32'h80,  32'h1234, 2'b11, 2'b01));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, RS_ACCESS, 1, 0, 32'h40,  32'h0,    2'b10, 2'b11));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b10, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b10, 2'b00, RS_ERROR,  1, 0, 32'h80,  32'h1234, 2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, RS_BUSY,   0, 0, 32'h80,  32'h1234, 2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, RS_ACCESS, 1, 0, 32'h80,  32'h1234, 2'b11, 2'b01));
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, RS_ACCESS, 1, 0, 32'h200, 32'h5555, 2'b11, 2'b10));
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, RS_FREE,   0, 0, 32'h0,   32'h0,    2'b11, 2'b11));

      foreach (tbl[r]) begin
         bus.iREN = tbl[r].iren; bus.dREN = tbl[r].dren; bus.dWEN = tbl[r].dwen;
         bus.ramstate = tbl[r].rs;
         #1;
         check($sformatf("vec%0d", r), dut_outs(),
               outs(tbl[r].ren, tbl[r].wen, tbl[r].addr, tbl[r].store, tbl[r].iwait, tbl[r].dwait));
         check($sformatf("vec%0d_load", r), {bus.iload, bus.dload}, {4{32'hDEADBEEF}});
         @(negedge clk);
      end

      // ---------------- reset mid-BUSY (pointer is 1 here) ----------------
      bus.dREN = 2'b10; bus.ramstate = RS_FREE;
      @(negedge clk);
      bus.ramstate = RS_BUSY;
      #1;
      check("rst_pre_busy", dut_outs(), outs(1, 0, 32'h80, 32'h1234, 2'b11, 2'b11));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_drop", dut_outs(), outs(0, 0, 0, 0, 2'b11, 2'b11));
      @(negedge clk);
      rst_n = 1'b1;
      bus.dREN = 2'b11; bus.ramstate = RS_FREE;
      #1;
      check("rst_idle_after", dut_outs(), outs(0, 0, 0, 0, 2'b11, 2'b11));
      @(negedge clk);
      bus.ramstate = RS_ACCESS;
      #1;
      check("rst_first_grant_cpu0", dut_outs(), outs(1, 0, 32'h200, 32'h5555, 2'b11, 2'b10));
      @(negedge clk);

      // ---------------- back-to-back data requests, zero-wait RAM ----------------
      do_reset();
      fixed_addrs();
      bus.dREN = 2'b11; bus.ramstate = RS_ACCESS;
      low_cnt[0] = 0; low_cnt[1] = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         for (int p = 0; p < N; p++) if (!bus.dwait[p]) begin
            low_cnt[p]++;
            alt_order.push_back(p);
         end
         @(negedge clk);
      end
      check("alt_cnt0", 128'(low_cnt[0]), 128'd2);
      check("alt_cnt1", 128'(low_cnt[1]), 128'd2);
      check("alt_order", {96'd0, 128'(alt_order.size())}, 128'd4);
      if (alt_order.size() == 4)
         check("alt_seq", 128'({alt_order[0][7:0], alt_order[1][7:0], alt_order[2][7:0], alt_order[3][7:0]}),
               128'h00010001);

      // ---------------- icache starvation / aging ----------------
      do_reset();
      fixed_addrs();
      bus.dREN = 2'b01; bus.iREN = 2'b10; bus.ramstate = RS_ACCESS;
      i_low_cnt = 0; first_i_low = -1; d0_low_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!bus.iwait[1]) begin
            i_low_cnt++;
            if (first_i_low < 0) first_i_low = c;
         end
         if (!bus.dwait[0]) d0_low_cnt++;
         @(negedge clk);
      end
`ifdef CACHE_ARB_AGE_EN
      check("age_first_grant_cycle", 128'(first_i_low), 128'd17);
      check("age_grant_count", 128'(i_low_cnt), 128'd2);
`else
      check("starve_icache_grants", 128'(i_low_cnt), 128'd0);
      check("starve_dcache_grants", 128'(d0_low_cnt), 128'd20);
`endif

      // ---------------- randomized traffic against the model ----------------
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < N; p++) begin
            if ($urandom_range(3) == 0) begin
               bus.iREN[p] = 1'($urandom_range(1));
               dsel = 2'($urandom_range(2));
               bus.dREN[p] = (dsel == 2'd1);
               bus.dWEN[p] = (dsel == 2'd2);
            end
            bus.iaddr[p]  = $urandom;
            bus.daddr[p]  = $urandom;
            bus.dstore[p] = $urandom;
         end
         bus.ramstate = 2'($urandom_range(3));
         bus.ramload  = $urandom;
         #1;
         model_outputs();
         check($sformatf("rand%0d", c), dut_outs(), outs(e_ren, e_wen, e_addr, e_store, e_iwait, e_dwait));
         if (c % 100 == 0)
            check($sformatf("rand%0d_load", c), {bus.iload, bus.dload}, {4{bus.ramload}});
         @(posedge clk);
         model_step();
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Sequential arbiter that shares the single RAM port among the instruction and data caches of all CPUs. It sits between the per-CPU caches blocks and the RAM model. It grants one word-sized access at a time, holds that grant until RAM reports completion, and returns per-requester wait and load signals. Data requests beat instruction requests, and CPUs are served round-robin.

## Interface
Parameters:
- CPUS, 2, number of CPUs; each CPU has one icache port and one dcache port.
- AGE_LIMIT, 8, consecutive lost arbitrations before an icache request is promoted (only used with CACHE_ARB_AGE_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  CPUS  icache read request, one bit per CPU.
- iaddr  in  CPUS×32  icache word address.
- dREN  in  CPUS  dcache read request.
- dWEN  in  CPUS  dcache write request; must not be asserted together with dREN.
- daddr  in  CPUS×32  dcache word address.
- dstore  in  CPUS×32  dcache write data.
- iwait  out  CPUS  1 = icache access not complete this cycle.
- dwait  out  CPUS  1 = dcache access not complete this cycle.
- iload  out  CPUS×32  equals ramload for every CPU.
- dload  out  CPUS×32  equals ramload for every CPU.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

## Operation
- FSM states:
  - IDLE: no grant is held. If any request is present, register the winner (cpu index, class D or I) and move to BUSY. Otherwise stay in IDLE.
  - BUSY: RAM outputs are driven from the granted requester's live inputs.
    - ramstate==ACCESS: the granted wait bit goes to 0 for this cycle, the round-robin pointer becomes (granted cpu+1) mod CPUS, and the FSM returns to IDLE.
    - Granted request deasserts before ACCESS (abandon): return to IDLE; no wait bit goes low and the pointer is unchanged.
    - ramstate ERROR, BUSY or FREE: stay in BUSY.
- Winner selection in IDLE:
  - The data class (dREN|dWEN) of all CPUs is scanned first, starting at the round-robin pointer and wrapping modulo CPUS.
  - The instruction class (iREN) is scanned only if no data request is present, with the same pointer and order.
- RAM outputs:
  - In BUSY with class D: ramREN=dREN[g], ramWEN=dWEN[g], ramaddr=daddr[g], ramstore=dstore[g].
  - In BUSY with class I: ramREN=iREN[g], ramWEN=0, ramaddr=iaddr[g], ramstore=0.
  - In IDLE: all RAM outputs are 0.
- Wait bits: every wait bit is 1 except the granted class/cpu in a BUSY cycle with ramstate==ACCESS.
- Simultaneous events:
  - A new request arriving in the same cycle as ACCESS is not considered until the IDLE cycle that follows.
  - A requester whose access completes and which still asserts its request is re-arbitrated normally in IDLE.

## Timing
- Reset values (asynchronous): state IDLE, pointer 0, grant cleared, age counters 0. Outputs: iwait/dwait all 1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Request seen in IDLE at cycle t:
  - RAM strobes are asserted at t+1.
  - If RAM answers ACCESS at cycle a≥t+1, wait goes low at a and the next grant can be registered at a+1.
  - Minimum cost is 2 cycles per access; there is one IDLE bubble between back-to-back accesses.
- iload/dload are combinational from ramload and are valid only in the cycle wait is low.
- Reset asserted mid-BUSY aborts the access immediately. The RAM strobes drop asynchronously.

## Configuration
- CACHE_ARB_AGE_EN defined:
  - Each CPU has a counter that increments when its iREN loses arbitration in IDLE, and clears when its icache is granted or iREN is low.
  - When a counter reaches AGE_LIMIT, that icache request is promoted above the data class. Among promoted requests, the round-robin order applies.
- Without the macro: pure data-over-instruction priority. The counters and AGE_LIMIT logic are absent, so instruction starvation is possible.

## Test plan
- Single CPU0 iREN, iaddr=0x40, RAM answers ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 for those 3 cycles; iwait[0]=0 and iload[0]=0xDEADBEEF in exactly the ACCESS cycle; FSM returns to IDLE.
- CPU0 iREN and CPU1 dWEN (daddr=0x80, dstore=0x1234) in the same cycle -> CPU1 write is granted first (ramWEN=1, ramstore=0x1234), then CPU0 read after one bubble cycle.
- CPU0 and CPU1 both hold dREN continuously with zero-wait RAM -> grants alternate 0,1,0,1; each dwait is low once every 4 cycles.
- Granted dREN is dropped while ramstate=BUSY -> FSM returns to IDLE, dwait stays 1, and the pointer is unchanged.
- nRST pulsed low mid-BUSY -> ramREN=0 and all waits=1 at once; after release the first grant goes to CPU0.
- With CACHE_ARB_AGE_EN, CPU1 iREN held while CPU0 dREN is constant -> CPU1 icache is granted after 8 losses. Without the macro, CPU1 is never granted.
